// File: rtl/load_store_unit.sv
// Load/store master for a word-addressed 32-bit data memory: sequences reads, writes and
// read-modify-write for sub-word stores, and sign/zero-extends load results.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        Clk_40,
    input  logic        Reset_40,
    input  logic        Req_40,
    input  logic [2:0]  Op_40,
    input  logic [31:0] Addr_40,
    input  logic [31:0] StoreData_40,
    output logic        Busy_40,
    output logic        Done_40,
    output logic        Error_40,
    output logic [31:0] LoadData_40,
    output logic [31:0] MemAddress_40,
    output logic [31:0] MemWriteData_40,
    output logic        MemRead_40,
    output logic        MemWrite_40,
    input  logic [31:0] MemReadData_40
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [15:0] sdata_q;
    logic        err_q;
    logic [31:0] load_data_q;
    logic [31:0] wdata_q;
    logic        req_err;

    // Replace the addressed byte/halfword lane of the fetched word
    function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [2:0] op,
                                               input logic [1:0] a, input logic [15:0] s);
        logic [31:0] r;
        r = w;
        if (op == OP_SH) r[{a[1], 4'b0000} +: 16] = s;
        else             r[{a, 3'b000} +: 8]      = s[7:0];
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] op,
                                           input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (op)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            default: return w;
        endcase
    endfunction

    // Alignment and range check on the incoming request
    always_comb begin
        req_err = 1'b0;
        case (Op_40)
            OP_LW, OP_SW:         req_err = (Addr_40[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: req_err = Addr_40[0];
            default:              req_err = 1'b0;
        endcase
        if (Addr_40[31:2] >= 30'(MEM_WORDS)) req_err = 1'b1;
    end

    always_ff @(posedge Clk_40 or posedge Reset_40) begin
        if (Reset_40) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Req_40) begin
                    if (req_err)             state_d = RESP;
                    else if (Op_40 == OP_SW) state_d = WR;
                    else                     state_d = RD;
                end
            end
            RD:      state_d = (op_q == OP_SH || op_q == OP_SB) ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from the state register alone
    always_comb begin
        Busy_40     = 1'b0;
        Done_40     = 1'b0;
        Error_40    = 1'b0;
        MemRead_40  = 1'b0;
        MemWrite_40 = 1'b0;
        case (state_q)
            RD:   begin Busy_40 = 1'b1; MemRead_40 = 1'b1; end
            WR:   begin Busy_40 = 1'b1; MemWrite_40 = 1'b1; end
            RESP: begin Busy_40 = 1'b1; Done_40 = 1'b1; Error_40 = err_q; end
            default: ;
        endcase
    end

    // Request capture, fetched-word merge and load result
    always_ff @(posedge Clk_40 or posedge Reset_40) begin
        if (Reset_40) begin
            op_q        <= OP_LW;
            addr_q      <= 32'h0;
            sdata_q     <= 16'h0;
            err_q       <= 1'b0;
            load_data_q <= 32'h0;
            wdata_q     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Req_40) begin
                        op_q    <= Op_40;
                        addr_q  <= Addr_40;
                        sdata_q <= StoreData_40[15:0];
                        err_q   <= req_err;
                        if (Op_40 == OP_SW && !req_err) wdata_q <= StoreData_40;
                    end
                end
                RD: begin
                    if (op_q == OP_SH || op_q == OP_SB)
                        wdata_q <= merge_lane(MemReadData_40, op_q, addr_q[1:0], sdata_q);
                    else
                        load_data_q <= extend(MemReadData_40, op_q, addr_q[1:0]);
                end
                default: ;
            endcase
        end
    end

    assign LoadData_40     = load_data_q;
    assign MemAddress_40   = {addr_q[31:2], 2'b00};
    assign MemWriteData_40 = wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side master for the 32-bit word-addressed data memory. The memory side has a combinational read path and a posedge write.
- Accepts one load/store request at a time from the MEM pipeline stage and sequences MemRead/MemWrite accesses on the memory port.
- Handles byte and halfword accesses: sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Returns load data with a Done pulse and stalls the pipeline while busy.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory. Word index = address>>2; index >= MEM_WORDS is out of range.

Ports:
- Clk_40  in  1  rising-edge clock.
- Reset_40  in  1  asynchronous, active-high reset.
- Req_40  in  1  request strobe; sampled only in IDLE.
- Op_40  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- Addr_40  in  32  byte address.
- StoreData_40  in  32  store data; SH uses [15:0], SB uses [7:0].
- Busy_40  out  1  high in any state other than IDLE.
- Done_40  out  1  one-cycle completion pulse.
- Error_40  out  1  valid with Done_40: misaligned or out-of-range; no memory access was made.
- LoadData_40  out  32  extended load result, held until the next load completes.
- MemAddress_40  out  32  word-aligned address to memory: {addr[31:2],2'b00}.
- MemWriteData_40  out  32  write word to memory.
- MemRead_40  out  1  memory read enable.
- MemWrite_40  out  1  memory write enable.
- MemReadData_40  in  32  memory read data, valid in the same cycle as MemRead_40.

Behaviour:

Reset:
- State = IDLE. All outputs 0: Busy, Done, Error, LoadData, MemAddress, MemWriteData, MemRead, MemWrite.
- Effect is immediate (asynchronous), including mid-operation. A pending write is abandoned and memory is untouched.

Little-endian lanes:
- Byte k = word[8k+7:8k].
- Halfword at addr[1]=0 is [15:0]; at addr[1]=1 it is [31:16].

Error (checked in IDLE on Req):
- Misaligned: LW/SW with addr[1:0] != 0; LH/LHU/SH with addr[0] != 0.
- Out of range: (addr>>2) >= MEM_WORDS.
- On error: go straight to RESP with the error flag set. No MemRead/MemWrite is ever asserted.

FSM:
- IDLE:
  - Busy=0.
  - On Req_40: latch Op, Addr, StoreData.
  - Error → RESP. SW → WR. All loads and SH/SB → RD.
  - Req while not IDLE is ignored; the pipeline must hold Req until it sees Done.
- RD:
  - MemRead=1, MemAddress = aligned address.
  - Capture MemReadData into the word register at the clock edge.
  - Loads → RESP. SH/SB → WR.
- WR:
  - MemWrite=1, MemAddress = aligned address.
  - MemWriteData: SW = StoreData; SH/SB = captured word with the addressed lane(s) replaced by StoreData[15:0] / [7:0].
  - → RESP.
- RESP:
  - Done=1, Error = latched flag.
  - For loads without error: LoadData updated this cycle. LW = word; LH/LB sign-extend; LHU/LBU zero-extend.
  - → IDLE. A new request can be accepted the following cycle.

Port qualification:
- MemRead and MemWrite are decoded from the state register only (no combinational path from Req/Addr) and are never high together.
- MemAddress and MemWriteData are don't-care outside RD/WR but are held stable through each state.

Latency (request sampled in IDLE at edge T):
- LW/LH/LB: RD in T+1, Done in T+2.
- SW: WR in T+1, Done in T+2.
- SH/SB: RD T+1, WR T+2, Done T+3.
- Error: Done in T+1.

Test Plan:
- Preload word 0x10 = 0x80817F02. LB 0x12 → LoadData 0xFFFFFF81. LBU 0x12 → 0x00000081. LH 0x12 → 0xFFFF8081. LHU 0x10 → 0x00007F02. Each has Done 2 cycles after Req, one MemRead cycle with MemAddress 0x10.
- SB 0x11 with StoreData 0x123456AA on word 0x80817F02 → RD at T+1, MemWrite at T+2 with MemWriteData 0x8081AA02, Done at T+3. Then LW 0x10 returns 0x8081AA02.
- SW 0x20 with 0xDEADBEEF → no MemRead, one MemWrite cycle, Done at T+2. SH 0x22 with 0x0000CAFE → memory word becomes 0xCAFEBEEF.
- LW 0x06 and SH 0x21 → Error=1 with Done at T+1, MemRead/MemWrite stay 0, LoadData unchanged. LW 0x100 (index 64) → Error=1.
- Pulse Req_40 again while Busy → ignored, no extra memory access. Back-to-back LW/SW with Req held high → each completes with the exact latency above and Done is never asserted twice per request.
- Assert Reset_40 asynchronously during WR of an SB → MemWrite drops immediately, the memory word is unchanged, and Busy=0 after reset.
